instr_fetch_unit: RTL

- Instruction fetch front end: owns the PC, issues word reads to instruction memory and delivers each fetched instruction plus its PC to the decode stage.
- Decode is where the opcode decoder sits; this block is the producer side of that interface.
- Accepts PC redirects from execute (taken branch, JAL, JALR).
- Stops fetching after delivering a HALT instruction (opcode 7'b1111111).

---
 rtl/instr_fetch_unit.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/instr_fetch_unit.sv
// ============================================================================
// instr_fetch_unit
// Instruction fetch front end: owns the PC, reads imem, hands words to decode.
// Optional delivered-instruction counter enabled by FETCH_INSTR_COUNT_EN.
// Revision: 1.0
// ============================================================================
`default_nettype none

module instr_fetch_unit #(
    parameter int              PC_W     = 32,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic            imem_req,
    output logic [PC_W-1:0] imem_addr,
    input  logic            imem_ready,
    input  logic            imem_rvalid,
    input  logic [31:0]     imem_rdata,
    output logic            instr_valid,
    output logic [31:0]     instr,
    output logic [PC_W-1:0] instr_pc,
    input  logic            instr_ready,
    input  logic            redirect_valid,
    input  logic [PC_W-1:0] redirect_pc,
    output logic            halted,
    output logic [31:0]     instr_count
);

    localparam logic [6:0] C_HALT_OPCODE = 7'b1111111;

    typedef enum logic [1:0] {
        S_FETCH  = 2'd0,
        S_WAIT   = 2'd1,
        S_HOLD   = 2'd2,
        S_HALTED = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic [PC_W-1:0] req_pc_q, req_pc_d;
    logic            kill_q, kill_d;
    logic            instr_valid_q, instr_valid_d;
    logic [31:0]     instr_q, instr_d;
    logic [PC_W-1:0] instr_pc_q, instr_pc_d;
    logic            halted_q, halted_d;

    logic [PC_W-1:0] w_redirect_pc;
    logic            w_accept;

    assign w_redirect_pc = redirect_pc & ~PC_W'(3);
    assign w_accept      = instr_valid_q && instr_ready && !redirect_valid;

    // Held low while in reset so memory never sees a request before release.
    assign imem_req  = rst_n && (state_q == S_FETCH) && !redirect_valid;
    assign imem_addr = pc_q;

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        req_pc_d      = req_pc_q;
        kill_d        = kill_q;
        instr_valid_d = instr_valid_q;
        instr_d       = instr_q;
        instr_pc_d    = instr_pc_q;
        halted_d      = halted_q;

        case (state_q)
            S_FETCH: begin
                if (redirect_valid) begin
                    pc_d = w_redirect_pc;
                end else if (imem_ready) begin
                    req_pc_d = pc_q;
                    pc_d     = pc_q + PC_W'(4);
                    state_d  = S_WAIT;
                end
            end
            S_WAIT: begin
                if (redirect_valid) begin
                    pc_d = w_redirect_pc;
                    if (imem_rvalid) begin
                        kill_d  = 1'b0;
                        state_d = S_FETCH;
                    end else begin
                        // Response still in flight: remember to drop it.
                        kill_d = 1'b1;
                    end
                end else if (imem_rvalid) begin
                    if (kill_q) begin
                        kill_d  = 1'b0;
                        state_d = S_FETCH;
                    end else begin
                        instr_d       = imem_rdata;
                        instr_pc_d    = req_pc_q;
                        instr_valid_d = 1'b1;
                        state_d       = S_HOLD;
                    end
                end
            end
            S_HOLD: begin
                if (redirect_valid) begin
                    pc_d          = w_redirect_pc;
                    instr_valid_d = 1'b0;
                    state_d       = S_FETCH;
                end else if (w_accept) begin
                    instr_valid_d = 1'b0;
                    if (instr_q[6:0] == C_HALT_OPCODE) begin
                        halted_d = 1'b1;
                        state_d  = S_HALTED;
                    end else begin
                        state_d = S_FETCH;
                    end
                end
            end
            S_HALTED: begin
                instr_valid_d = 1'b0;
            end
            default: begin
                state_d = S_FETCH;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_FETCH;
            pc_q          <= RESET_PC;
            req_pc_q      <= '0;
            kill_q        <= 1'b0;
            instr_valid_q <= 1'b0;
            instr_q       <= '0;
            instr_pc_q    <= '0;
            halted_q      <= 1'b0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            req_pc_q      <= req_pc_d;
            kill_q        <= kill_d;
            instr_valid_q <= instr_valid_d;
            instr_q       <= instr_d;
            instr_pc_q    <= instr_pc_d;
            halted_q      <= halted_d;
        end
    end

    assign instr_valid = instr_valid_q;
    assign instr       = instr_q;
    assign instr_pc    = instr_pc_q;
    assign halted      = halted_q;

`ifdef FETCH_INSTR_COUNT_EN
    logic [31:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (w_accept) begin
            count_d = count_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign instr_count = count_q;
`else
    assign instr_count = '0;
`endif

endmodule

`default_nettype wire
